alu_reg_sequencer: RTL and testbench

//  Upstream operand/control stage for the 16-bit ALU (inA/inB/inC/opc -> outW/zer/neg).

---
 rtl/alu_reg_sequencer_pkg.sv | 16 +
 rtl/alu_reg_sequencer_if.sv | 27 ++
 rtl/alu_reg_sequencer_seq_regfile.sv | 45 ++++
 rtl/alu_reg_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_reg_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_reg_sequencer_pkg.sv
// Shared definitions for the ALU operand/writeback sequencer: sequencer states
// and the default datapath geometry.
package alu_reg_sequencer_pkg;

  localparam int OPC_W     = 3;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

endpackage

// File: rtl/alu_reg_sequencer_if.sv
// Op request channel: a requester issues one register-to-register ALU op
// over a valid/ready handshake.
interface alu_reg_sequencer_if
  import alu_reg_sequencer_pkg::*;
#(
  parameter int AW = 2
);

  logic             op_valid;
  logic             op_ready;
  logic [OPC_W-1:0] op_opc;
  logic [AW-1:0]    op_srca;
  logic [AW-1:0]    op_srcb;
  logic [AW-1:0]    op_dst;
  logic             op_cin;

  modport master (
    output op_valid, op_opc, op_srca, op_srcb, op_dst, op_cin,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_opc, op_srca, op_srcb, op_dst, op_cin,
    output op_ready
  );

endinterface

// File: rtl/alu_reg_sequencer_seq_regfile.sv
// NREGS x WIDTH register file with two asynchronous read ports and two write
// ports; write port B (result writeback) wins an address clash with port A.
module seq_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wa_en_i,
  input  logic [AW-1:0]    wa_addr_i,
  input  logic [WIDTH-1:0] wa_data_i,
  input  logic             wb_en_i,
  input  logic [AW-1:0]    wb_addr_i,
  input  logic [WIDTH-1:0] wb_data_i,
  input  logic [AW-1:0]    ra_addr_i,
  output logic [WIDTH-1:0] ra_data_o,
  input  logic [AW-1:0]    rb_addr_i,
  output logic [WIDTH-1:0] rb_data_o
);

  logic [WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_en_i && (wb_addr_i == AW'(i))) begin
          regs_q[i] <= wb_data_i;
        end else if (wa_en_i && (wa_addr_i == AW'(i))) begin
          regs_q[i] <= wa_data_i;
        end else begin
          regs_q[i] <= regs_q[i];
        end
      end
    end
  end

  assign ra_data_o = regs_q[ra_addr_i];
  assign rb_data_o = regs_q[rb_addr_i];

endmodule

// File: rtl/alu_reg_sequencer.sv
// Operand/control stage for the external combinational ALU: accepts an op,
// drives registered operands for a full cycle, then writes the result back.
module alu_reg_sequencer
  import alu_reg_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_reg_sequencer_if.slave   op_if,
  input  logic                 ld_en_i,
  input  logic [AW-1:0]        ld_addr_i,
  input  logic [WIDTH-1:0]     ld_data_i,
  output logic [WIDTH-1:0]     alu_a_o,
  output logic [WIDTH-1:0]     alu_b_o,
  output logic                 alu_c_o,
  output logic [OPC_W-1:0]     alu_opc_o,
  input  logic [WIDTH-1:0]     alu_w_i,
  input  logic                 alu_zer_i,
  input  logic                 alu_neg_i,
  output logic                 res_valid_o,
  output logic [WIDTH-1:0]     res_data_o,
  output logic                 flag_zer_o,
  output logic                 flag_neg_o,
  output logic                 busy_o
);

  state_e state_q, state_d;

  logic [OPC_W-1:0] opc_q;
  logic [AW-1:0]    srca_q, srcb_q, dst_q;
  logic             cin_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic             alu_c_q;
  logic [OPC_W-1:0] alu_opc_q;
  logic [WIDTH-1:0] res_w_q;
  logic             res_zer_q, res_neg_q;
  logic [WIDTH-1:0] res_data_q;
  logic             flag_zer_q, flag_neg_q;

  logic             ready;
  logic             wb_en;
  logic             accept;
  logic [WIDTH-1:0] rd_a, rd_b;

  assign accept = op_if.op_valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    wb_en = 1'b0;
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_WB:   wb_en = 1'b1;
      default: begin
        ready = 1'b0;
        wb_en = 1'b0;
      end
    endcase
  end

  // Op capture, operand fetch, result capture and writeback of the status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q      <= '0;
      srca_q     <= '0;
      srcb_q     <= '0;
      dst_q      <= '0;
      cin_q      <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_c_q    <= 1'b0;
      alu_opc_q  <= '0;
      res_w_q    <= '0;
      res_zer_q  <= 1'b0;
      res_neg_q  <= 1'b0;
      res_data_q <= '0;
      flag_zer_q <= 1'b0;
      flag_neg_q <= 1'b0;
    end else begin
      if (accept) begin
        opc_q  <= op_if.op_opc;
        srca_q <= op_if.op_srca;
        srcb_q <= op_if.op_srcb;
        dst_q  <= op_if.op_dst;
        cin_q  <= op_if.op_cin;
      end
      if (state_q == ST_FETCH) begin
        alu_a_q   <= rd_a;
        alu_b_q   <= rd_b;
        alu_c_q   <= cin_q;
        alu_opc_q <= opc_q;
      end
      if (state_q == ST_EXEC) begin
        res_w_q   <= alu_w_i;
        res_zer_q <= alu_zer_i;
        res_neg_q <= alu_neg_i;
      end
      if (wb_en) begin
        res_data_q <= res_w_q;
        flag_zer_q <= res_zer_q;
        flag_neg_q <= res_neg_q;
      end
    end
  end

  // Reads see pre-edge contents; a load in the FETCH cycle is not forwarded.
  seq_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wa_en_i   (ld_en_i),
    .wa_addr_i (ld_addr_i),
    .wa_data_i (ld_data_i),
    .wb_en_i   (wb_en),
    .wb_addr_i (dst_q),
    .wb_data_i (res_w_q),
    .ra_addr_i (srca_q),
    .ra_data_o (rd_a),
    .rb_addr_i (srcb_q),
    .rb_data_o (rd_b)
  );

  assign op_if.op_ready = ready;
  assign busy_o         = ~ready;
  assign res_valid_o    = wb_en;
  assign alu_a_o        = alu_a_q;
  assign alu_b_o        = alu_b_q;
  assign alu_c_o        = alu_c_q;
  assign alu_opc_o      = alu_opc_q;
  assign res_data_o     = res_data_q;
  assign flag_zer_o     = flag_zer_q;
  assign flag_neg_o     = flag_neg_q;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench for alu_reg_sequencer, closing the loop through a small
// behavioural ALU (000: A+B+C, 001: A-B, 111: pass A for register peeks).
module tb_alu_reg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_en = 1'b0;
  logic [1:0]  ld_addr = 2'd0;
  logic [15:0] ld_data = 16'd0;
  logic [15:0] alu_a, alu_b, alu_w;
  logic        alu_c, alu_zer, alu_neg;
  logic [2:0]  alu_opc;
  logic        res_valid, flag_zer, flag_neg, busy;
  logic [15:0] res_data;

  int total = 0;
  int bad   = 0;

  alu_reg_sequencer_if #(.AW(2)) op_bus ();

  alu_reg_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .op_if       (op_bus),
    .ld_en_i     (ld_en),
    .ld_addr_i   (ld_addr),
    .ld_data_i   (ld_data),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_c_o     (alu_c),
    .alu_opc_o   (alu_opc),
    .alu_w_i     (alu_w),
    .alu_zer_i   (alu_zer),
    .alu_neg_i   (alu_neg),
    .res_valid_o (res_valid),
    .res_data_o  (res_data),
    .flag_zer_o  (flag_zer),
    .flag_neg_o  (flag_neg),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_opc)
      3'b000:  alu_w = alu_a + alu_b + {15'd0, alu_c};
      3'b001:  alu_w = alu_a - alu_b;
      3'b111:  alu_w = alu_a;
      default: alu_w = 16'd0;
    endcase
    alu_zer = (alu_w == 16'd0);
    alu_neg = alu_w[15];
  end

  task automatic load_reg(input logic [1:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] opc, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [1:0] d, input logic c, input logic ld_wb,
                        input logic [1:0] la, input logic [15:0] ldd,
                        output logic [15:0] rd, output logic rz, output logic rn,
                        output int lat);
    int guard;
    guard = 0;
    while (!op_bus.op_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    op_bus.op_valid = 1'b1; op_bus.op_opc = opc; op_bus.op_srca = sa;
    op_bus.op_srcb = sb; op_bus.op_dst = d; op_bus.op_cin = c;
    @(posedge clk); #1;
    op_bus.op_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    if (ld_wb) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ldd;
    end
    @(posedge clk); #1;
    ld_en = 1'b0;
    rd = res_data; rz = flag_zer; rn = flag_neg;
  endtask

  task automatic peek_reg(input logic [1:0] a, output logic [15:0] v);
    logic z, n;
    int   l;
    run_op(3'b111, a, a, a, 1'b0, 1'b0, 2'd0, 16'd0, v, z, n, l);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b1; op_bus.op_valid = 1'b0; ld_en = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    total++; if (op_bus.op_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", op_bus.op_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    total++; if ({res_data, flag_zer, flag_neg} !== 18'd0) begin bad++; $display("FAIL rst_result: got %h/%b/%b want 0", res_data, flag_zer, flag_neg); end
    total++; if ({alu_a, alu_b, alu_c, alu_opc} !== 36'd0) begin bad++; $display("FAIL rst_alu: got %h %h %b %b want 0", alu_a, alu_b, alu_c, alu_opc); end
    for (int i = 0; i < 4; i++) begin
      peek_reg(2'(i), v);
      total++; if (v !== 16'd0) begin bad++; $display("FAIL rst_reg%0d: got %h want 0000", i, v); end
    end
  endtask

  task automatic test_add();
    logic [15:0] rd, v; logic z, n; int lat;
    load_reg(2'd0, 16'd5);
    load_reg(2'd1, 16'd7);
    run_op(3'b000, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 2'd0, 16'd0, rd, z, n, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL add_latency: got %0d want 3", lat); end
    total++; if (rd !== 16'd12) begin bad++; $display("FAIL add_res: got %h want 000c", rd); end
    total++; if ({z, n} !== 2'b00) begin bad++; $display("FAIL add_flags: got z%b n%b want z0 n0", z, n); end
    total++; if ({alu_a, alu_b} !== {16'd5, 16'd7}) begin bad++; $display("FAIL add_alu_hold: got %h %h want 0005 0007", alu_a, alu_b); end
    peek_reg(2'd2, v);
    total++; if (v !== 16'd12) begin bad++; $display("FAIL add_r2: got %h want 000c", v); end
  endtask

  task automatic test_sub();
    logic [15:0] rd, v; logic z, n; int lat;
    run_op(3'b001, 2'd0, 2'd1, 2'd3, 1'b0, 1'b0, 2'd0, 16'd0, rd, z, n, lat);
    total++; if (rd !== 16'hFFFE) begin bad++; $display("FAIL sub_res: got %h want fffe", rd); end
    total++; if ({z, n} !== 2'b01) begin bad++; $display("FAIL sub_flags: got z%b n%b want z0 n1", z, n); end
    run_op(3'b001, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 2'd0, 16'd0, rd, z, n, lat);
    total++; if (rd !== 16'd0) begin bad++; $display("FAIL subz_res: got %h want 0000", rd); end
    total++; if ({z, n} !== 2'b10) begin bad++; $display("FAIL subz_flags: got z%b n%b want z1 n0", z, n); end
    peek_reg(2'd3, v);
    total++; if (v !== 16'd0) begin bad++; $display("FAIL subz_r3: got %h want 0000", v); end
  endtask

  task automatic test_wrap();
    logic [15:0] rd, v; logic z, n; int lat;
    load_reg(2'd0, 16'hFFFF);
    run_op(3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 16'd0, rd, z, n, lat);
    total++; if (rd !== 16'hFFFF) begin bad++; $display("FAIL wrap_res: got %h want ffff", rd); end
    total++; if ({z, n} !== 2'b01) begin bad++; $display("FAIL wrap_flags: got z%b n%b want z0 n1", z, n); end
    total++; if (alu_c !== 1'b1) begin bad++; $display("FAIL wrap_cin: got %b want 1", alu_c); end
    peek_reg(2'd0, v);
    total++; if (v !== 16'hFFFF) begin bad++; $display("FAIL wrap_r0: got %h want ffff", v); end
  endtask

  task automatic test_ld_clash();
    logic [15:0] rd, v; logic z, n; int lat;
    run_op(3'b000, 2'd1, 2'd1, 2'd2, 1'b0, 1'b1, 2'd2, 16'hAAAA, rd, z, n, lat);
    total++; if (rd !== 16'h000E) begin bad++; $display("FAIL clash_res: got %h want 000e", rd); end
    peek_reg(2'd2, v);
    total++; if (v !== 16'h000E) begin bad++; $display("FAIL clash_same_r2: got %h want 000e", v); end
    run_op(3'b000, 2'd2, 2'd2, 2'd3, 1'b1, 1'b1, 2'd1, 16'h0123, rd, z, n, lat);
    total++; if (rd !== 16'h001D) begin bad++; $display("FAIL clash2_res: got %h want 001d", rd); end
    peek_reg(2'd3, v);
    total++; if (v !== 16'h001D) begin bad++; $display("FAIL clash_diff_r3: got %h want 001d", v); end
    peek_reg(2'd1, v);
    total++; if (v !== 16'h0123) begin bad++; $display("FAIL clash_diff_r1: got %h want 0123", v); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic exp_rdy, exp_vld;
    op_bus.op_valid = 1'b1; op_bus.op_opc = 3'b000; op_bus.op_srca = 2'd1;
    op_bus.op_srcb = 2'd1; op_bus.op_dst = 2'd0; op_bus.op_cin = 1'b0;
    for (int c = 0; c < 12; c++) begin
      exp_rdy = ((c % 4) == 0);
      exp_vld = ((c % 4) == 3);
      total++; if (op_bus.op_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready c%0d: got %b want %b", c, op_bus.op_ready, exp_rdy); end
      total++; if (busy !== ~exp_rdy) begin bad++; $display("FAIL b2b_busy c%0d: got %b want %b", c, busy, ~exp_rdy); end
      total++; if (res_valid !== exp_vld) begin bad++; $display("FAIL b2b_res_valid c%0d: got %b want %b", c, res_valid, exp_vld); end
      @(posedge clk); #1;
    end
    op_bus.op_valid = 1'b0;
    total++; if (res_data !== 16'h0246) begin bad++; $display("FAIL b2b_res: got %h want 0246", res_data); end
    peek_reg(2'd0, v);
    total++; if (v !== 16'h0246) begin bad++; $display("FAIL b2b_r0: got %h want 0246", v); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    op_bus.op_valid = 1'b1; op_bus.op_opc = 3'b000; op_bus.op_srca = 2'd0;
    op_bus.op_srcb = 2'd0; op_bus.op_dst = 2'd3; op_bus.op_cin = 1'b0;
    @(posedge clk); #1;
    op_bus.op_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (alu_a !== 16'h0246) begin bad++; $display("FAIL mid_exec_a: got %h want 0246", alu_a); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (op_bus.op_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", op_bus.op_ready); end
    total++; if ({res_data, flag_zer, flag_neg} !== 18'd0) begin bad++; $display("FAIL mid_result: got %h/%b/%b want 0", res_data, flag_zer, flag_neg); end
    total++; if ({alu_a, alu_b, alu_c, alu_opc} !== 36'd0) begin bad++; $display("FAIL mid_alu: got %h %h %b %b want 0", alu_a, alu_b, alu_c, alu_opc); end
    for (int c = 0; c < 4; c++) begin
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_no_valid c%0d: got %b want 0", c, res_valid); end
      @(posedge clk); #1;
    end
    peek_reg(2'd3, v);
    total++; if (v !== 16'd0) begin bad++; $display("FAIL mid_r3: got %h want 0000", v); end
  endtask

  initial begin
    op_bus.op_valid = 1'b0; op_bus.op_opc = 3'd0; op_bus.op_srca = 2'd0;
    op_bus.op_srcb = 2'd0; op_bus.op_dst = 2'd0; op_bus.op_cin = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_wrap();
    test_ld_clash();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
